// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types for the data memory controller.
//   funct3_e  - RISC-V load/store widths (store names alias the load codes)
//   rsp_err_e - response error codes
//   state_e   - controller FSM state
//   load_extend() - picks the byte/halfword at a lane and sign/zero-extends it
package dmem_pkg;

  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101
  } funct3_e;

  // Stores share encodings with the signed loads.
  localparam funct3_e F3_SB = F3_LB;
  localparam funct3_e F3_SH = F3_LH;
  localparam funct3_e F3_SW = F3_LW;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_ILLEGAL  = 2'd3
  } rsp_err_e;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      F3_LB:   r = {{24{b[7]}}, b};
      F3_LH:   r = {{16{h[15]}}, h};
      F3_LBU:  r = {24'd0, b};
      F3_LHU:  r = {16'd0, h};
      default: r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: DEPTH_WORDS x 32 synchronous single-port RAM.
//   clk_i   - clock
//   we_i    - per-byte write enable (bit b writes wdata_i[8b+7:8b])
//   re_i    - read enable; rdata_o only changes on a cycle with re_i = 1
//   addr_i  - word index
//   wdata_i - write data
//   rdata_o - registered read data (old contents when read and write collide)
module dmem_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
  input  logic             clk_i,
  input  logic [3:0]       we_i,
  input  logic             re_i,
  input  logic [IDX_W-1:0] addr_i,
  input  logic [31:0]      wdata_i,
  output logic [31:0]      rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-addressed RISC-V data memory with valid/ready ports.
//   clk, rst_n            - clock, asynchronous active-low reset
//   clear                 - pulse in RUN restarts the zero-fill
//   req_valid/req_ready   - request handshake; req_we, req_addr, req_wdata,
//                           req_funct3 describe the access
//   rsp_valid/rsp_ready   - response handshake; rsp_rdata (extended load data,
//                           0 for stores/errors), rsp_err (rsp_err_e code)
//   init_busy             - high while the array is being zero-filled
// Handshake: a transfer happens on a rising edge where valid && ready; valid
// and its payload stay stable until that edge. The response path is a single
// register: a new request is taken when it is empty or being drained.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter int                ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic              init_busy
);

  localparam int                IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W:0]   SPAN  = (ADDR_W+1)'(4 * DEPTH_WORDS);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   init_cnt_q, init_cnt_d;

  logic               rsp_valid_q;
  rsp_err_e           err_q;
  logic               ld_ok_q;     // response carries load data
  logic [2:0]         f3_q;
  logic [1:0]         lane_q;

  logic [ADDR_W-1:0]  off;
  logic [1:0]         lane;
  logic [IDX_W-1:0]   idx;
  logic               legal, oor, misal;
  rsp_err_e           err;
  logic [3:0]         be;
  logic [31:0]        wd;
  logic               accept;

  logic [3:0]         ram_we;
  logic               ram_re;
  logic [IDX_W-1:0]   ram_addr;
  logic [31:0]        ram_wdata;
  logic [31:0]        ram_rdata;

  // ---------------- request decode ----------------
  always_comb begin
    off  = req_addr - BASE_ADDR;   // wraps mod 2^ADDR_W
    lane = off[1:0];
    idx  = off[IDX_W+1:2];
    oor  = ({1'b0, off} >= SPAN);

    case (req_funct3)
      F3_LB, F3_LH, F3_LW: legal = 1'b1;
      F3_LBU, F3_LHU:      legal = !req_we;
      default:             legal = 1'b0;
    endcase

    case (req_funct3[1:0])
      2'b01:   misal = lane[0];
      2'b10:   misal = (lane != 2'd0);
      default: misal = 1'b0;
    endcase

    if (!legal)     err = ERR_ILLEGAL;
    else if (oor)   err = ERR_RANGE;
    else if (misal) err = ERR_MISALIGN;
    else            err = ERR_OK;

    // Data is replicated so every candidate lane sees the same byte/halfword.
    case (req_funct3[1:0])
      2'b00: begin
        be = 4'b0001 << lane;
        wd = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be = 4'b0011 << lane;
        wd = {2{req_wdata[15:0]}};
      end
      default: begin
        be = 4'b1111;
        wd = req_wdata;
      end
    endcase
  end

  assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
  assign accept    = req_valid && req_ready;

  // ---------------- FSM + RAM port mux ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      init_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_busy  = 1'b0;
    ram_we     = 4'b0000;
    ram_re     = 1'b0;
    ram_addr   = idx;
    ram_wdata  = wd;
    case (state_q)
      ST_INIT: begin
        init_busy  = 1'b1;
        ram_we     = 4'b1111;
        ram_addr   = init_cnt_q;
        ram_wdata  = '0;
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_d = ST_RUN;
      end
      default: begin
        if (accept) begin
          ram_re = 1'b1;
          if (req_we && (err == ERR_OK)) ram_we = be;
        end
        // A pending response is untouched here, so it still drains during INIT.
        if (clear) begin
          state_d    = ST_INIT;
          init_cnt_d = '0;
        end
      end
    endcase
  end

  dmem_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // ---------------- response register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      err_q       <= ERR_OK;
      ld_ok_q     <= 1'b0;
      f3_q        <= '0;
      lane_q      <= '0;
    end else if (accept) begin
      rsp_valid_q <= 1'b1;
      err_q       <= err;
      ld_ok_q     <= !req_we && (err == ERR_OK);
      f3_q        <= req_funct3;
      lane_q      <= lane;
    end else if (rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // Extension happens after the RAM read register; the metadata captured at
  // accept keeps it stable while the response stalls.
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = err_q;
  assign rsp_rdata = ld_ok_q ? load_extend(ram_rdata, f3_q, lane_q) : 32'd0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Testbench for data_mem_ctrl (DEPTH_WORDS = 16). Expected responses come from
// a byte-array reference model and are queued in exp_q at accept time.
module tb_data_mem_ctrl;

  localparam int DEPTH  = 16;
  localparam int NBYTES = DEPTH * 4;

  localparam logic [2:0] LB = 3'b000, LH = 3'b001, LW = 3'b010;
  localparam logic [2:0] LBU = 3'b100, LHU = 3'b101;
  localparam logic [2:0] SB = 3'b000, SH = 3'b001, SW = 3'b010;

  logic        clk = 1'b0;
  logic        rst_n, clear, req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid, rsp_ready, init_busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  ref_mem [NBYTES];
  logic [33:0] exp_q [$];
  logic [31:0] last_rdata, last_exp;
  logic [1:0]  last_err;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  data_mem_ctrl #(
    .DEPTH_WORDS (DEPTH),
    .ADDR_W      (32),
    .BASE_ADDR   (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_funct3 (req_funct3),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .init_busy  (init_busy)
  );

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic model_zero();
    for (int i = 0; i < NBYTES; i++) ref_mem[i] = 8'h00;
  endtask

  task automatic model_apply(input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [2:0] f3);
    int          nb;
    logic        legal;
    logic [31:0] off, val;
    logic [1:0]  err;
    off   = addr - 32'h0000_0000;
    nb    = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!legal)                err = 2'd3;
    else if (off >= NBYTES)    err = 2'd2;
    else if (off % nb != 0)    err = 2'd1;
    else                       err = 2'd0;
    val = 32'd0;
    if (err == 2'd0) begin
      if (we) begin
        for (int b = 0; b < nb; b++) ref_mem[off + b] = wdata[8*b +: 8];
      end else begin
        for (int b = 0; b < nb; b++) val = val | (32'(ref_mem[off + b]) << (8*b));
        if (!f3[2] && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
      end
    end
    if (we) val = 32'd0;
    exp_q.push_back({err, val});
  endtask

  // ---------------- driver tasks ----------------
  // Called on a negedge; returns on the negedge after the request is accepted.
  task automatic issue(input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3);
    int n;
    req_valid = 1'b1; req_we = we; req_addr = addr;
    req_wdata = wdata; req_funct3 = f3;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_ready_timeout", 32'(req_ready), 32'd1);
    @(posedge clk);
    model_apply(we, addr, wdata, f3);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic take_rsp(input string tag);
    logic [33:0] e;
    e = exp_q.pop_front();
    chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
    chk({tag, "_err"}, 32'(rsp_err), 32'(e[33:32]));
    last_rdata = rsp_rdata;
    last_err   = rsp_err;
    last_exp   = e[31:0];
  endtask

  task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [2:0] f3);
    rsp_ready = 1'b1;
    issue(we, addr, wdata, f3);
    take_rsp(tag);
  endtask

  // Counts negedges with init_busy high, starting at the current negedge.
  task automatic wait_init(input string tag);
    int cnt;
    cnt = 0;
    while (init_busy && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, "_cycles"}, 32'(cnt), 32'(DEPTH));
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        we;
    logic [31:0] addr, wdata;
    logic [2:0]  f3;

    rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_we = 1'b0;
    req_addr = '0; req_wdata = '0; req_funct3 = '0; rsp_ready = 1'b1;
    model_zero();
    repeat (3) @(negedge clk);

    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err",   32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);

    rst_n = 1'b1;
    wait_init("reset_init");

    xact("lw_top", 1'b0, 32'h3C, 32'h0, LW);
    chk("lw_top_lit", last_rdata, 32'h0000_0000);

    // Byte-lane merge and extension
    xact("sw10", 1'b1, 32'h10, 32'h8765_4321, SW);
    xact("sb13", 1'b1, 32'h13, 32'h0000_00AA, SB);
    xact("lw10", 1'b0, 32'h10, 32'h0, LW);
    chk("lw10_lit", last_rdata, 32'hAA65_4321);
    xact("lb13", 1'b0, 32'h13, 32'h0, LB);
    chk("lb13_lit", last_rdata, 32'hFFFF_FFAA);
    xact("lbu13", 1'b0, 32'h13, 32'h0, LBU);
    chk("lbu13_lit", last_rdata, 32'h0000_00AA);

    xact("sh22", 1'b1, 32'h22, 32'h0000_8001, SH);
    xact("lh22", 1'b0, 32'h22, 32'h0, LH);
    chk("lh22_lit", last_rdata, 32'hFFFF_8001);
    xact("lhu22", 1'b0, 32'h22, 32'h0, LHU);
    chk("lhu22_lit", last_rdata, 32'h0000_8001);
    xact("lw20", 1'b0, 32'h20, 32'h0, LW);
    chk("lw20_lit", last_rdata, 32'h8001_0000);

    // Error cases and their priority
    xact("lw11_mis", 1'b0, 32'h11, 32'h0, LW);
    chk("lw11_err_lit", 32'(last_err), 32'd1);
    xact("sw40_oor", 1'b1, 32'h40, 32'hDEAD_BEEF, SW);
    chk("sw40_err_lit", 32'(last_err), 32'd2);
    xact("lw00_nowr", 1'b0, 32'h00, 32'h0, LW);
    chk("lw00_nowr_lit", last_rdata, 32'h0000_0000);
    xact("f3_011", 1'b0, 32'h00, 32'h0, 3'b011);
    chk("f3_011_err_lit", 32'(last_err), 32'd3);
    xact("sh13_mis", 1'b1, 32'h13, 32'h1234, SH);
    xact("lw41_oor", 1'b0, 32'h41, 32'h0, LW);
    xact("f3_011_oor", 1'b0, 32'h41, 32'h0, 3'b011);
    xact("st_f3_100", 1'b1, 32'h00, 32'h55, 3'b100);
    xact("lh3e", 1'b0, 32'h3E, 32'h0, LH);

    // Stall: response held, no new request taken
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 32'h0, LW);
    take_rsp("stall");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rdata", rsp_rdata, last_exp);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_drained", 32'(rsp_valid), 32'd0);

    // Back-to-back random traffic, one response per cycle
    for (int i = 0; i < 40; i++) begin
      if (i > 0) take_rsp("b2b");
      we    = 1'($urandom_range(0, 1));
      f3    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 9) == 0) ? $urandom_range(64, 80) : $urandom_range(0, 15);
      if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3;
      wdata = $urandom;
      req_valid = 1'b1; req_we = we; req_addr = addr;
      req_wdata = wdata; req_funct3 = f3;
      chk("b2b_ready", 32'(req_ready), 32'd1);
      @(posedge clk);
      model_apply(we, addr, wdata, f3);
      @(negedge clk);
    end
    req_valid = 1'b0;
    take_rsp("b2b_last");
    @(negedge clk);

    // Clear with a pending response
    xact("sw04", 1'b1, 32'h04, 32'h1234_5678, SW);
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h04, 32'h0, LW);
    take_rsp("clr_pend");
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    chk("clr_busy", 32'(init_busy), 32'd1);
    chk("clr_pend_valid", 32'(rsp_valid), 32'd1);
    chk("clr_pend_rdata", rsp_rdata, 32'h1234_5678);
    rsp_ready = 1'b1;
    model_zero();
    wait_init("clear_init");
    for (int w = 0; w < DEPTH; w++) begin
      xact("clr_read", 1'b0, 32'(w * 4), 32'h0, LW);
      chk("clr_read_lit", last_rdata, 32'h0);
    end

    // Reset with a pending response
    @(negedge clk);
    xact("sw08", 1'b1, 32'h08, 32'hCAFE_F00D, SW);
    @(negedge clk);
    rsp_ready = 1'b0;
    issue(1'b0, 32'h08, 32'h0, LW);
    take_rsp("rst_pend");
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_rdata", rsp_rdata, 32'd0);
    chk("mid_rst_err",   32'(rsp_err), 32'd0);
    chk("mid_rst_ready", 32'(req_ready), 32'd0);
    chk("mid_rst_busy",  32'(init_busy), 32'd1);
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    wait_init("rst2_init");
    xact("rst_lw08", 1'b0, 32'h08, 32'h0, LW);
    chk("rst_lw08_lit", last_rdata, 32'h0);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
# data_mem_ctrl

Parametrised, byte-addressed RISC-V data memory with a valid/ready request/response interface. It sits on the CPU data port. It decodes load/store width from funct3 (LB/LH/LW/LBU/LHU/SB/SH/SW), performs byte-lane writes and sign/zero-extended reads, and flags misaligned, out-of-range and illegal accesses. After reset or a clear request, a built-in init state machine zero-fills the array before any request is accepted.

## Interface
- DEPTH_WORDS, 1024, number of 32-bit words; power of two, ≥ 4
- ADDR_W, 32, request address width
- BASE_ADDR, 32'h0000_0000, byte address of word 0; must be 4-byte aligned
- clk  in  1  clock; all state changes on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  single-cycle pulse; restarts zero-fill (honoured only in RUN)
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_we  in  1  1 = store, 0 = load
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- req_funct3  in  3  RISC-V funct3 of the load/store
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  2  0 OK, 1 misaligned, 2 out of range, 3 illegal funct3
- init_busy  out  1  high while zero-fill runs

## Operation
- FSM states: INIT, RUN. Reset and clear both enter INIT with init_cnt = 0.
- INIT: write 0 to word init_cnt each cycle, then increment. Leave for RUN after word DEPTH_WORDS-1 is written, so INIT lasts exactly DEPTH_WORDS cycles. In INIT, req_ready = 0 and init_busy = 1.
- RUN: req_ready = !rsp_valid || rsp_ready, giving a single-entry response register with full-throughput pass-through.
- off = (req_addr - BASE_ADDR) mod 2^ADDR_W. idx = off >> 2. lane = off[1:0].
- Out of range: off ≥ 4*DEPTH_WORDS. This check has priority over misalignment. Illegal funct3 has priority over both.
- Legal funct3: loads 000/001/010/100/101; stores 000/001/010.
- Misaligned: halfword with lane[0] = 1, or word with lane ≠ 0.
- Store: byte-enable = 0001<<lane (SB), 0011<<lane (SH), 1111 (SW). Data = wdata[7:0] or wdata[15:0] replicated across the lanes. Untouched bytes are preserved.
- Load: read word idx. Select the byte or halfword at lane, then sign-extend (000/001) or zero-extend (100/101); 010 returns the whole word.
- Any error: no array write; rsp_rdata = 0. Every accepted request, including stores and errors, produces exactly one response.
- clear while rsp_valid: the pending response is still delivered, and INIT starts in parallel.

## Timing
- Reset values: rsp_valid 0, rsp_rdata 0, rsp_err 0, req_ready 0, init_busy 1, state INIT, init_cnt 0.
- The first request can be accepted DEPTH_WORDS cycles after rst_n deasserts.
- Accept at edge N: the store writes at edge N. rsp_valid = 1 after edge N and holds, stable, until an edge with rsp_ready = 1.
- Read-after-write across consecutive requests returns the new data (separate cycles, sync RAM).
- Stall: rsp_rdata and rsp_err are held. The RAM read register updates only on accept.
- rst_n asserted mid-operation: the in-flight response is dropped, outputs take reset values immediately, and zero-fill restarts from word 0.
- init_cnt is log2(DEPTH_WORDS) bits wide; no wrap is possible because the terminal count ends INIT.

## Structure
- Package dmem_pkg holds:
  - typedef enum for funct3 (LB, LH, LW, LBU, LHU; SB, SH, SW aliases)
  - typedef enum for rsp_err codes
  - typedef enum for the FSM state
- Sub-module dmem_ram: DEPTH_WORDS × 32 synchronous single-port RAM with a 4-bit byte write enable and registered read data. The init writer and the request path share its port through a mux selected by state.

## Test plan
- Reset with DEPTH_WORDS = 16 -> init_busy high for exactly 16 cycles, then req_ready = 1; LW at 0x3C returns 0x0000_0000.
- SW 0x8765_4321 @0x10, then SB 0xAA @0x13 -> LW @0x10 returns 0xAA65_4321; LB @0x13 returns 0xFFFF_FFAA; LBU @0x13 returns 0x0000_00AA.
- SH 0x8001 @0x22 -> LH @0x22 returns 0xFFFF_8001; LHU returns 0x0000_8001; LW @0x20 returns 0x8001_0000.
- LW @0x11 -> rsp_err 1, rdata 0; SW @0x40 (DEPTH_WORDS = 16) -> rsp_err 2, and no write occurs; funct3 011 -> rsp_err 3.
- Hold rsp_ready low for 5 cycles after an LW -> rsp_rdata stable and req_ready 0 throughout. Back-to-back requests with rsp_ready held high -> one response per cycle.
- Pulse clear in RUN -> 16 cycles of init_busy, then all words read 0. Assert rst_n low during a pending response -> rsp_valid drops immediately.
